fp_div_8_16_32_seq: RTL and testbench

Sequential fused mantissa divider, the inverse counterpart of the fused mantissa multiplier fp_mul_8_16_32.
- Takes dividend and divisor mantissas (hidden bit included) in FP8, FP16 or FP32 format, selected by CONFIG_FP.
- Computes a truncated, normalized quotient mantissa with radix-2 restoring division, one quotient bit per cycle.
- Reports an exponent-decrement flag and a sticky bit to the downstream exponent/rounding stage.
- Valid/ready handshake on both input and output sides.

---
 rtl/fp_div_8_16_32_seq.sv | 156 +++++++++++++++
 tb/tb_fp_div_8_16_32_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fp_div_8_16_32_seq.sv
// Sequential radix-2 restoring mantissa divider for FP8/FP16/FP32 (hidden bit included).
// Produces one quotient bit per cycle and registers a normalized, truncated quotient with EXP_ADJ and STICKY flags.
module fp_div_8_16_32_seq #(
   parameter int WIDTH = 24,
   parameter int CFG_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CFG_W-1:0] CONFIG_FP,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] OUT,
   output logic             EXP_ADJ,
   output logic             STICKY,
   output logic             ERR,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int RW = WIDTH + 2;
   localparam int QW = WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_b;
   logic [RW-1:0]    r_rem;
   logic [QW-1:0]    r_q;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_m;
   logic             r_bad_in;
   logic [WIDTH-1:0] r_out;
   logic             r_exp_adj;
   logic             r_sticky;
   logic             r_err;

   logic [CW-1:0]    w_m_in;
   logic [WIDTH-1:0] w_in_mask;
   logic             w_hidden_ok;
   logic             w_ge;
   logic [RW-1:0]    w_rem_sub;
   logic [RW-1:0]    w_rem_next;
   logic [QW-1:0]    w_q_next;
   logic             w_last;
   logic             w_q_top;
   logic [WIDTH-1:0] w_res_out;
   logic             w_res_sticky;
   logic [WIDTH-1:0] w_ones;

   // Mantissa width M for the requested format; the reserved code falls back to FP32.
   always_comb begin
      case (CONFIG_FP)
         2'b00:   w_m_in = CW'(4);
         2'b01:   w_m_in = CW'(11);
         default: w_m_in = CW'(24);
      endcase
   end

   assign w_in_mask   = ~({WIDTH{1'b1}} << w_m_in);
   assign w_hidden_ok = IN1[w_m_in - CW'(1)] & IN2[w_m_in - CW'(1)];

   // One restoring step: compare, conditionally subtract, shift the partial remainder.
   assign w_ge         = (r_rem >= {2'b00, r_b});
   assign w_rem_sub    = w_ge ? (r_rem - {2'b00, r_b}) : r_rem;
   assign w_rem_next   = {w_rem_sub[RW-2:0], 1'b0};
   assign w_q_next     = {r_q[QW-2:0], w_ge};
   assign w_last       = (r_cnt == r_m);
   assign w_q_top      = w_q_next[r_m];
   assign w_res_out    = w_q_top ? w_q_next[WIDTH:1] : w_q_next[WIDTH-1:0];
   assign w_res_sticky = (w_q_top & w_q_next[0]) | (w_rem_next != '0);
   assign w_ones       = ~({WIDTH{1'b1}} << r_m);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred on any path.
   always_comb begin
      w_state_next = r_state;
      IN_READY     = 1'b0;
      OUT_VALID    = 1'b0;
      case (r_state)
         S_IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) w_state_next = S_BUSY;
         end
         S_BUSY: begin
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_b       <= '0;
         r_rem     <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         r_m       <= '0;
         r_bad_in  <= 1'b0;
         r_out     <= '0;
         r_exp_adj <= 1'b0;
         r_sticky  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (IN_VALID) begin
                  r_rem    <= {2'b00, IN1 & w_in_mask};
                  r_b      <= IN2 & w_in_mask;
                  r_q      <= '0;
                  r_cnt    <= '0;
                  r_m      <= w_m_in;
                  r_bad_in <= ~w_hidden_ok;
               end
            end
            S_BUSY: begin
               r_rem <= w_rem_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  if (r_bad_in) begin
                     r_out     <= w_ones;
                     r_exp_adj <= 1'b0;
                     r_sticky  <= 1'b0;
                     r_err     <= 1'b1;
                  end else begin
                     r_out     <= w_res_out;
                     r_exp_adj <= ~w_q_top;
                     r_sticky  <= w_res_sticky;
                     r_err     <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign OUT     = r_out;
   assign EXP_ADJ = r_exp_adj;
   assign STICKY  = r_sticky;
   assign ERR     = r_err;

endmodule

// File: tb/tb_fp_div_8_16_32_seq.sv
// Directed, table-driven bench for fp_div_8_16_32_seq with hand-computed quotients,
// plus sequences for backpressure, ignored requests and asynchronous reset mid-division.
module tb_fp_div_8_16_32_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  CONFIG_FP;
   logic [23:0] IN1, IN2;
   logic        IN_VALID;
   logic        IN_READY;
   logic [23:0] OUT;
   logic        EXP_ADJ, STICKY, ERR, OUT_VALID;
   logic        OUT_READY;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_div_8_16_32_seq #(.WIDTH(24), .CFG_W(2)) dut (
      .clk(clk), .rst(rst), .CONFIG_FP(CONFIG_FP), .IN1(IN1), .IN2(IN2),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT(OUT), .EXP_ADJ(EXP_ADJ),
      .STICKY(STICKY), .ERR(ERR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
   );

   typedef struct {
      string       name;
      logic [1:0]  cfg;
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] q;
      logic        adj;
      logic        sticky;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive a request at the negedge and return once the acceptance edge has passed.
   task automatic issue(input logic [1:0] cfg, input logic [23:0] a, input logic [23:0] b);
      @(negedge clk);
      CONFIG_FP = cfg; IN1 = a; IN2 = b; IN_VALID = 1'b1;
      @(posedge clk);
      #1;
      IN_VALID = 1'b0;
      IN1 = 24'h0; IN2 = 24'h0; CONFIG_FP = 2'b11;
   endtask

   // Count edges after acceptance until OUT_VALID, bounded.
   task automatic wait_valid(input string name, input int lat);
      int cyc = 0;
      while (cyc < 60) begin
         if (cyc > 0) @(posedge clk);
         else @(posedge clk);
         cyc++;
         #1;
         if (OUT_VALID) break;
         if (cyc == 1) check({name, "_busy_in_ready"}, {31'b0, IN_READY}, 32'd0);
      end
      check({name, "_latency"}, cyc, lat);
   endtask

   task automatic check_result(input vec_t v);
      check({v.name, "_out"},    {8'h0, OUT},       {8'h0, v.q});
      check({v.name, "_exp_adj"}, {31'b0, EXP_ADJ}, {31'b0, v.adj});
      check({v.name, "_sticky"}, {31'b0, STICKY},   {31'b0, v.sticky});
      check({v.name, "_err"},    {31'b0, ERR},      {31'b0, v.err});
   endtask

   task automatic run_vec(input vec_t v);
      issue(v.cfg, v.a, v.b);
      wait_valid(v.name, v.lat);
      check_result(v);
      check({v.name, "_done_in_ready"}, {31'b0, IN_READY}, 32'd0);
      @(posedge clk);
      #1;
      check({v.name, "_released"}, {30'b0, OUT_VALID, IN_READY}, 32'd1);
      check({v.name, "_out_held"}, {8'h0, OUT}, {8'h0, v.q});
   endtask

   initial begin
      vecs[0] = '{"fp32_15_15",  2'b10, 24'hC00000, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, 25};
      vecs[1] = '{"fp32_10_15",  2'b10, 24'h800000, 24'hC00000, 24'hAAAAAA, 1'b1, 1'b1, 1'b0, 25};
      vecs[2] = '{"fp32_15_10",  2'b10, 24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 25};
      vecs[3] = '{"fp16_175_125", 2'b01, 24'h000700, 24'h000500, 24'h000599, 1'b0, 1'b1, 1'b0, 12};
      vecs[4] = '{"fp16_1_1",    2'b01, 24'h000400, 24'h000400, 24'h000400, 1'b0, 1'b0, 1'b0, 12};
      vecs[5] = '{"fp8_8_f",     2'b00, 24'h000008, 24'h00000F, 24'h000008, 1'b1, 1'b1, 1'b0, 5};
      vecs[6] = '{"fp8_f_8",     2'b00, 24'h00000F, 24'h000008, 24'h00000F, 1'b0, 1'b0, 1'b0, 5};
      vecs[7] = '{"fp32_err",    2'b10, 24'hC00000, 24'h400000, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 25};
      vecs[8] = '{"fp8_err",     2'b00, 24'h000004, 24'h00000C, 24'h00000F, 1'b0, 1'b0, 1'b1, 5};
      vecs[9] = '{"rsvd_as_fp32", 2'b11, 24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 25};

      rst = 1'b1; CONFIG_FP = 2'b10; IN1 = '0; IN2 = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;
      #12;
      check("reset_in_ready", {31'b0, IN_READY}, 32'd1);
      check("reset_outputs", {4'h0, OUT, EXP_ADJ, STICKY, ERR, OUT_VALID}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Backpressure: result held 10 cycles while a competing request is ignored.
      OUT_READY = 1'b0;
      issue(2'b00, 24'h000008, 24'h00000F);
      wait_valid("bp", 5);
      check_result(vecs[5]);
      @(negedge clk);
      CONFIG_FP = 2'b10; IN1 = 24'hC00000; IN2 = 24'h800000; IN_VALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_flags", {28'b0, OUT_VALID, IN_READY, EXP_ADJ, STICKY}, 32'b1011);
         check("bp_hold_out", {8'h0, OUT}, 32'h000008);
      end
      @(negedge clk);
      OUT_READY = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_idle", {30'b0, OUT_VALID, IN_READY}, 32'd1);
      @(posedge clk);
      #1;
      check("bp_accept_next", {31'b0, IN_READY}, 32'd0);
      IN_VALID = 1'b0;
      wait_valid("bp_next", 25);
      check_result(vecs[2]);
      @(posedge clk);
      #1;

      // Asynchronous reset at BUSY count=10 abandons the division.
      issue(2'b10, 24'h800000, 24'hC00000);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", {31'b0, IN_READY}, 32'd1);
      check("arst_outputs", {4'h0, OUT, EXP_ADJ, STICKY, ERR, OUT_VALID}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (OUT_VALID) break;
      end
      check("arst_no_stale", {31'b0, OUT_VALID}, 32'd0);
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
